// File: rtl/branch_redirect_ctrl_if.sv
// rtl/branch_redirect_ctrl_if.sv - IF/EX/redirect/update bundle for branch_redirect_ctrl
interface branch_redirect_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
);
   logic              if_valid;
   logic [ADDR_W-1:0] if_pc;
   logic [ADDR_W-1:0] if_pred_pc;
   logic              if_stall;
   logic              ex_valid;
   logic [ADDR_W-1:0] ex_pc;
   logic              ex_is_br;
   logic              ex_jalr;
   logic              ex_taken;
   logic [ADDR_W-1:0] ex_target;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              flush;
   logic              upd_valid;
   logic [ADDR_W-1:0] upd_pc;
   logic [ADDR_W-1:0] upd_target;
   logic              upd_taken;
   logic              upd_jalr;
   logic [CNT_W-1:0]  br_cnt;
   logic [CNT_W-1:0]  miss_cnt;
   logic              err;

   modport master (
      output if_valid, if_pc, if_pred_pc, ex_valid, ex_pc, ex_is_br, ex_jalr, ex_taken, ex_target,
      input  if_stall, redirect_valid, redirect_pc, flush, upd_valid, upd_pc, upd_target,
             upd_taken, upd_jalr, br_cnt, miss_cnt, err
   );

   modport slave (
      input  if_valid, if_pc, if_pred_pc, ex_valid, ex_pc, ex_is_br, ex_jalr, ex_taken, ex_target,
      output if_stall, redirect_valid, redirect_pc, flush, upd_valid, upd_pc, upd_target,
             upd_taken, upd_jalr, br_cnt, miss_cnt, err
   );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - predicted-next-PC queue, EX-time check, redirect/flush and predictor update
module branch_redirect_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   branch_redirect_ctrl_if.slave   bus
);
   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc_q   [DEPTH];
   logic [ADDR_W-1:0] r_pred_q [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W:0]    r_count;

   logic              r_redirect_valid;
   logic [ADDR_W-1:0] r_redirect_pc;
   logic              r_flush;
   logic              r_upd_valid;
   logic [ADDR_W-1:0] r_upd_pc;
   logic [ADDR_W-1:0] r_upd_target;
   logic              r_upd_taken;
   logic              r_upd_jalr;
   logic [CNT_W-1:0]  r_br_cnt;
   logic [CNT_W-1:0]  r_miss_cnt;
   logic              r_err;

   logic              w_run;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic [ADDR_W-1:0] w_actual;
   logic              w_desync;
   logic              w_miss;
   logic              w_br;

   assign w_run    = (r_state == ST_RUN);
   assign w_full   = (r_count == (PTR_W+1)'(DEPTH));
   assign w_empty  = (r_count == '0);
   assign w_push   = bus.if_valid && !w_full && w_run;
   assign w_pop    = bus.ex_valid && w_run;
   assign w_br     = w_pop && bus.ex_is_br;
   assign w_actual = (bus.ex_is_br && bus.ex_taken) ? bus.ex_target : bus.ex_pc + ADDR_W'(4);
   // Empty queue or wrong head PC means the queue lost track of the pipeline.
   assign w_desync = w_pop && (w_empty || r_pc_q[r_rd_ptr] != bus.ex_pc);
   assign w_miss   = w_desync || (w_pop && r_pred_q[r_rd_ptr] != w_actual);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state          <= ST_RUN;
         r_wr_ptr         <= '0;
         r_rd_ptr         <= '0;
         r_count          <= '0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
         r_flush          <= 1'b0;
         r_upd_valid      <= 1'b0;
         r_upd_pc         <= '0;
         r_upd_target     <= '0;
         r_upd_taken      <= 1'b0;
         r_upd_jalr       <= 1'b0;
         r_br_cnt         <= '0;
         r_miss_cnt       <= '0;
         r_err            <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_pc_q[i]   <= '0;
            r_pred_q[i] <= '0;
         end
      end else begin
         case (r_state)
            ST_RUN:   r_state <= w_miss ? ST_FLUSH : ST_RUN;
            default:  r_state <= ST_RUN;
         endcase

         r_redirect_valid <= w_miss;
         r_flush          <= w_miss;
         r_redirect_pc    <= w_miss ? w_actual : '0;

         r_upd_valid <= w_br;
         if (w_br) begin
            r_upd_pc     <= bus.ex_pc;
            r_upd_target <= w_actual;
            r_upd_taken  <= bus.ex_taken;
            r_upd_jalr   <= bus.ex_jalr;
         end

         if (w_br && r_br_cnt != '1)
            r_br_cnt <= r_br_cnt + CNT_W'(1);
         if (w_miss && r_miss_cnt != '1)
            r_miss_cnt <= r_miss_cnt + CNT_W'(1);
         if (w_desync)
            r_err <= 1'b1;

         // A miss wipes the queue, including anything pushed this same cycle.
         if (w_miss) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) begin
               r_pc_q[r_wr_ptr]   <= bus.if_pc;
               r_pred_q[r_wr_ptr] <= bus.if_pred_pc;
               r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop)
               r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)
               r_count <= r_count + (PTR_W+1)'(1);
            else if (!w_push && w_pop)
               r_count <= r_count - (PTR_W+1)'(1);
         end
      end
   end

   assign bus.if_stall       = w_full;
   assign bus.redirect_valid = r_redirect_valid;
   assign bus.redirect_pc    = r_redirect_pc;
   assign bus.flush          = r_flush;
   assign bus.upd_valid      = r_upd_valid;
   assign bus.upd_pc         = r_upd_pc;
   assign bus.upd_target     = r_upd_target;
   assign bus.upd_taken      = r_upd_taken;
   assign bus.upd_jalr       = r_upd_jalr;
   assign bus.br_cnt         = r_br_cnt;
   assign bus.miss_cnt       = r_miss_cnt;
   assign bus.err            = r_err;
endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequences the branch predictor and the front-end PC across speculation. Keeps an in-order queue of the next-PC the predictor chose for every fetched instruction. Checks each entry against the resolved outcome when the instruction leaves EX. On a mismatch it issues a one-cycle redirect and flush, and it schedules the registered predictor-table update. Sits between IF (pc_reg/predictor) and EX.

## Interface
Parameters:
- ADDR_W, 32, instruction address width
- DEPTH, 4, queue entries (power of two, ≥2); covers IF→EX instructions in flight
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  single clock; everything sampled on rising edge
- rst  in  1  asynchronous, active-low reset
- if_valid  in  1  IF issues an instruction this cycle
- if_pc  in  ADDR_W  PC of issued instruction
- if_pred_pc  in  ADDR_W  next PC chosen by predictor (target if predicted taken, else pc+4)
- if_stall  out  1  queue full; IF must not assert if_valid
- ex_valid  in  1  an instruction completes EX this cycle
- ex_pc  in  ADDR_W  its PC
- ex_is_br  in  1  branch/jump instruction
- ex_jalr  in  1  instruction is JALR
- ex_taken  in  1  resolved taken
- ex_target  in  ADDR_W  resolved target
- redirect_valid  out  1  load redirect_pc into pc_reg
- redirect_pc  out  ADDR_W  correct next PC
- flush  out  1  kill IF/ID and ID/EX contents
- upd_valid  out  1  write predictor entry
- upd_pc, upd_target  out  ADDR_W  entry index PC / target
- upd_taken, upd_jalr  out  1  outcome; predictor ignores writes with upd_jalr=1
- br_cnt, miss_cnt  out  CNT_W  resolved branches / redirects, saturating
- err  out  1  sticky queue desync flag

## Operation
- Queue: circular FIFO of {pc, pred_pc}, with wrapping read/write pointers and a count of 0..DEPTH.
  - if_stall = (count==DEPTH), combinational.
  - A push happens when if_valid and not full and state==RUN.
  - if_valid while full is ignored. This holds even with a simultaneous pop.
- Resolution (state RUN, ex_valid):
  - actual = ex_is_br&&ex_taken ? ex_target : ex_pc+4, computed modulo 2^ADDR_W.
  - Pop the head.
  - A miss is any of: queue empty, head.pc≠ex_pc, or head.pred_pc≠actual.
  - The empty and pc-mismatch cases also set err.
- States:
  - RUN → FLUSH on a miss.
  - FLUSH → RUN unconditionally after one cycle.
  - In FLUSH, if_valid and ex_valid are ignored: no push, pop, update or count.
- On a miss, at the clock edge:
  - The queue is cleared (pointers and count reset).
  - Any same-cycle push is discarded.
- Counters:
  - br_cnt increments per resolved ex_is_br.
  - miss_cnt increments per miss.
  - Both hold at all-ones.
- err clears only on reset.

## Timing
- Reset (rst low, asynchronous): every output is 0, state=RUN, count=0, pointers=0.
- Redirect latency is 1 cycle.
  - A miss in cycle N gives redirect_valid=flush=1 and redirect_pc=actual during cycle N+1 only.
- Update latency is 1 cycle.
  - ex_valid&&ex_is_br in RUN during cycle N gives upd_* in cycle N+1 for exactly one cycle, whether hit or miss.
  - upd_valid is 0 otherwise.
- Push and pop in the same cycle (RUN, no miss): count is unchanged. When empty, the pop is treated as a miss, so the push is discarded.
- Back-to-back misses are impossible. The cycle after a miss is always FLUSH.
- Reset asserted mid-FLUSH: outputs drop immediately and the controller returns to RUN with an empty queue.

## Test plan
- Reset, then push pc 0x00 pred 0x04 and pop with ex_pc=0x00, non-branch → no redirect, upd_valid=0, count back to 0.
- Push pc 0x10 pred 0x14; resolve ex_is_br, taken, target 0x40 → next cycle redirect_valid=flush=1, redirect_pc=0x40, upd_valid=1, upd_taken=1, miss_cnt=1; queue empty; following cycle if_valid is ignored.
- Four pushes with no pops → if_stall=1; a fifth if_valid is dropped. Pop four correct entries in order (pointer wrap) → no redirect, if_stall deasserts after the first pop.
- ex_valid on an empty queue → err=1 (sticky), redirect_pc=ex_pc+4 next cycle.
- JALR at pc 0x20, predicted 0x24, resolved target 0x80 → redirect to 0x80, upd_jalr=1. Set pc=0xFFFFFFFC non-branch, predicted 0x0 → hit (wrap).
- Assert rst low asynchronously during a FLUSH cycle → redirect_valid, flush, counters and err all 0 before the next edge.
